// File: rtl/io_bus_if.sv
// Processor-side I/O port of io_bus_controller: request/write qualifiers in,
// read data and the one-cycle completion pulse out.
interface io_bus_if;
  logic       io_req;
  logic       io_we;
  logic [7:0] io_addr;
  logic [7:0] io_wdata;
  logic [7:0] io_rdata;
  logic       io_done;

  modport master (
    output io_req, io_we, io_addr, io_wdata,
    input  io_rdata, io_done
  );

  modport slave (
    input  io_req, io_we, io_addr, io_wdata,
    output io_rdata, io_done
  );
endinterface

// File: rtl/io_bus_controller.sv
// Sequences processor I/O onto the VGA-shared display memory, the PS/2 scan-code FIFO and control registers.
// Define IO_STARVE_GUARD_EN to let a processor access pre-empt VGA after STARVE_MAX waiting cycles.
module io_bus_controller #(
  parameter int DMEM_AW    = 12,
  parameter int KB_DEPTH   = 8,
  parameter int STARVE_MAX = 64
) (
  input  logic               clk,
  input  logic               rst,
  io_bus_if.slave            bus,
  input  logic               kb_valid,
  input  logic [7:0]         kb_code,
  input  logic               vga_fetch,
  input  logic [DMEM_AW-1:0] vga_addr,
  output logic [DMEM_AW-1:0] dmem_addr,
  output logic [7:0]         dmem_wdata,
  output logic               dmem_we,
  input  logic [7:0]         dmem_rdata,
  output logic [7:0]         cursor,
  output logic               vga_miss
);
  localparam int PW = DMEM_AW - 8;
  localparam int KW = $clog2(KB_DEPTH);

  typedef enum logic [1:0] {IDLE, MEM, RLAT, DONE} state_t;

  state_t        state_r;
  logic [7:0]    rdata_r;
  logic          done_r;
  logic [PW-1:0] page_r;
  logic [7:0]    cursor_r;
  logic [7:0]    fifo_mem_r [KB_DEPTH];
  logic [KW-1:0] wr_ptr_r;
  logic [KW-1:0] rd_ptr_r;
  logic [KW:0]   count_r;
  logic          overflow_r;

  logic          is_reg_s;
  logic          reg_acc_s;
  logic          empty_s;
  logic          full_s;
  logic          pop_s;
  logic          push_s;
  logic          grant_s;
  logic          mem_go_s;
  logic [7:0]    reg_rdata_s;

  assign is_reg_s  = (bus.io_addr >= 8'hF0);
  assign reg_acc_s = (state_r == IDLE) && bus.io_req && is_reg_s;
  assign empty_s   = (count_r == {(KW+1){1'b0}});
  assign full_s    = (count_r == (KW+1)'(KB_DEPTH));
  assign pop_s     = reg_acc_s && !bus.io_we && (bus.io_addr == 8'hF1) && !empty_s;
  // A full FIFO still accepts a code when the head leaves in the same cycle.
  assign push_s    = kb_valid && (!full_s || pop_s);

`ifdef IO_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_MAX + 1);
  logic [SW-1:0] starve_r;
  logic          starve_force_s;

  assign starve_force_s = (state_r == MEM) && (starve_r >= SW'(STARVE_MAX));
  assign grant_s        = !vga_fetch || starve_force_s;
  assign vga_miss       = starve_force_s && vga_fetch;

  // Counts cycles the processor has waited in MEM behind VGA.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_r <= {SW{1'b0}};
    end else if ((state_r == MEM) && !grant_s) begin
      starve_r <= starve_r + SW'(1);
    end else begin
      starve_r <= {SW{1'b0}};
    end
  end
`else
  localparam int unused_starve_max = STARVE_MAX;
  assign grant_s  = !vga_fetch;
  assign vga_miss = 1'b0;
`endif

  assign mem_go_s   = (state_r == MEM) && grant_s;
  assign dmem_addr  = mem_go_s ? {page_r, bus.io_addr} : vga_addr;
  assign dmem_we    = mem_go_s && bus.io_we;
  assign dmem_wdata = bus.io_wdata;

  assign bus.io_rdata = rdata_r;
  assign bus.io_done  = done_r;
  assign cursor       = cursor_r;

  // Register-space read data for the current request address.
  always_comb begin
    reg_rdata_s = 8'h00;
    case (bus.io_addr)
      8'hF0:   reg_rdata_s = {6'b000000, overflow_r, !empty_s};
      8'hF1:   reg_rdata_s = empty_s ? 8'h00 : fifo_mem_r[rd_ptr_r];
      8'hF2:   reg_rdata_s = cursor_r;
      8'hF3:   reg_rdata_s = 8'(page_r);
      default: reg_rdata_s = 8'h00;
    endcase
  end

  // Access sequencer with registered read data, done pulse and control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      done_r   <= 1'b0;
      rdata_r  <= 8'h00;
      page_r   <= {PW{1'b0}};
      cursor_r <= 8'h00;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.io_req) begin
            if (is_reg_s) begin
              if (bus.io_we) begin
                case (bus.io_addr)
                  8'hF2:   cursor_r <= bus.io_wdata;
                  8'hF3:   page_r   <= bus.io_wdata[PW-1:0];
                  default: ;
                endcase
              end else begin
                rdata_r <= reg_rdata_s;
              end
              done_r  <= 1'b1;
              state_r <= DONE;
            end else begin
              state_r <= MEM;
            end
          end
        end
        MEM: begin
          if (grant_s) begin
            if (bus.io_we) begin
              done_r  <= 1'b1;
              state_r <= DONE;
            end else begin
              state_r <= RLAT;
            end
          end
        end
        RLAT: begin
          rdata_r <= dmem_rdata;
          done_r  <= 1'b1;
          state_r <= DONE;
        end
        DONE:    state_r <= IDLE;
        default: state_r <= IDLE;
      endcase
    end
  end

  // Scan-code FIFO pointers, occupancy and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r   <= {KW{1'b0}};
      rd_ptr_r   <= {KW{1'b0}};
      count_r    <= {(KW+1){1'b0}};
      overflow_r <= 1'b0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + KW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + KW'(1);
      count_r <= count_r + {{KW{1'b0}}, push_s} - {{KW{1'b0}}, pop_s};
      if (kb_valid && !push_s) begin
        overflow_r <= 1'b1;
      end else if (reg_acc_s && bus.io_we && (bus.io_addr == 8'hF0)) begin
        overflow_r <= 1'b0;
      end
    end
  end

  // Scan-code storage; contents are don't-care until pushed.
  always_ff @(posedge clk) begin
    if (push_s) fifo_mem_r[wr_ptr_r] <= kb_code;
  end
endmodule

// File: doc/io_bus_controller.md
Name: io_bus_controller

Overview:
- Sequences processor I/O accesses (io_req/io_we/io_addr/io_wdata) onto the shared I/O resources.
- Resources: the single-port display character memory, which is shared with the VGA scan-out fetcher; a PS/2 scan-code FIFO; and small control registers.
- Sits between the processor I/O port and the io_interface blocks (PS/2 decoder, VGA text engine).
- Arbitrates display memory with VGA having priority, and returns a one-cycle io_done handshake.

Parameters:
- DMEM_AW, 12, display memory address width. Must be 8 + page register width.
- KB_DEPTH, 8, scan-code FIFO depth. Must be a power of two, at least 2.
- STARVE_MAX, 64, maximum cycles a processor memory access waits behind VGA. Used only with the optional feature.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- io_req  in  1  processor access request; held until io_done
- io_we  in  1  1 = write, 0 = read; stable while io_req is high
- io_addr  in  8  I/O address
- io_wdata  in  8  write data
- io_rdata  out  8  read data; valid while io_done is high
- io_done  out  1  one-cycle completion pulse
- kb_valid  in  1  one-cycle strobe from the PS/2 decoder
- kb_code  in  8  scan code, valid with kb_valid
- vga_fetch  in  1  VGA engine requests display memory this cycle
- vga_addr  in  DMEM_AW  VGA fetch address
- dmem_addr  out  DMEM_AW  display memory address
- dmem_wdata  out  8  display memory write data
- dmem_we  out  1  display memory write enable
- dmem_rdata  in  8  display memory read data; 1-cycle synchronous latency
- cursor  out  8  cursor position register, to the VGA engine
- vga_miss  out  1  pulse: VGA fetch was pre-empted (optional feature only; tied 0 otherwise)

Behaviour:
- **Clocking and reset:** single clock domain; all state updates on the rising clk edge. Synchronous rst (active-high) forces:
  - state IDLE
  - io_done 0, io_rdata 0x00
  - FIFO empty, overflow flag 0
  - page 0, cursor 0x00
  - starve counter 0, vga_miss 0
  - An in-flight access is abandoned with no io_done. The processor must re-issue it.
- **Address map:**
  - 0x00–0xEF: display memory cell. Memory address = {page, io_addr}.
  - 0xF0: KB_STATUS, read = {6'b0, overflow, nonempty}. Any write clears overflow.
  - 0xF1: KB_DATA. Read pops the FIFO head; reading an empty FIFO returns 0x00 with no pop. Writes are ignored.
  - 0xF2: CURSOR, read/write.
  - 0xF3: PAGE, read/write. Low (DMEM_AW-8) bits are stored; upper bits read as 0.
  - 0xF4–0xFF: reads return 0x00, writes are ignored. Both complete normally.
- **State machine (states IDLE, MEM, RLAT, DONE):**
  - IDLE:
    - io_req with a register address: perform the register read/write and load io_rdata (reads) this edge, then go to DONE.
    - io_req with a memory address: go to MEM.
  - MEM:
    - If vga_fetch=1, stay in MEM. VGA owns the memory.
    - Otherwise drive dmem_addr={page, io_addr} and dmem_we=io_we, with dmem_wdata=io_wdata. A write goes to DONE; a read goes to RLAT.
  - RLAT: io_rdata <= dmem_rdata, then go to DONE.
  - DONE: io_done=1 for exactly this cycle; io_req is ignored; go to IDLE.
- **Latency with no contention:**
  - Register access: io_done in the 2nd cycle after io_req is sampled.
  - Memory write: 3rd cycle.
  - Memory read: 4th cycle.
- **Memory mux (combinational):** vga_fetch=1 gives dmem_addr=vga_addr and dmem_we=0, except during a granted pre-emption (optional feature). When neither side is active, dmem_we=0 and dmem_addr=vga_addr.
- **FIFO:**
  - kb_valid pushes kb_code.
  - Push when full drops the code and sets overflow (sticky), except when a KB_DATA pop occurs in the same cycle. In that case both the pop and the push succeed.
  - Simultaneous push and pop on an empty FIFO: the pop returns 0x00 and the push lands.
  - Pointers wrap modulo KB_DEPTH. Occupancy counter range is 0..KB_DEPTH.

Optional Feature:
- Macro: IO_STARVE_GUARD_EN.
- **Defined:**
  - A counter increments each cycle MEM waits behind vga_fetch; it is cleared on leaving MEM.
  - When the count reaches STARVE_MAX, the next MEM cycle grants the processor even if vga_fetch=1.
  - That same cycle vga_miss=1 for one cycle; the VGA engine reuses its previous data.
- **Undefined:** no counter. VGA has absolute priority and vga_miss is constant 0.

Test Plan:
1. Reset, then write 0x41 to io_addr 0x05 with page 0 and no vga_fetch -> dmem_we=1, dmem_addr=0x005, dmem_wdata=0x41 in MEM; io_done one cycle later, 3 cycles after the request.
2. Write PAGE=0x3, then read io_addr 0x10 with memory returning 0x5A -> dmem_addr=0x310, io_rdata=0x5A while io_done=1.
3. Hold vga_fetch=1 for 10 cycles during a processor write -> no dmem_we while vga_fetch is high; write occurs the first cycle vga_fetch=0. With IO_STARVE_GUARD_EN and STARVE_MAX=4, the write happens after 4 waiting cycles and vga_miss pulses once.
4. Push 9 codes 0x01..0x09 with KB_DEPTH=8 -> KB_STATUS=0x03. Eight KB_DATA reads return 0x01..0x08; a ninth returns 0x00; KB_STATUS=0x02. Writing KB_STATUS then gives 0x00.
5. FIFO full plus kb_valid(0x77) coincident with a KB_DATA pop -> overflow stays 0 and 0x77 is read last.
6. Assert rst while in MEM waiting on vga_fetch -> next cycle state IDLE, io_done=0, cursor=0x00, no dmem_we issued.
